mode_ram: RTL
=============

Name: mode_ram

Overview:
- Parametrised single-port synchronous RAM with per-access write-mode selection: write-first, read-first or no-change.
- Adds byte-enable writes, a valid/ready request handshake, a registered read-data valid flag, and a post-reset sequential clear engine.
- Serves as the general storage primitive for register files and scratch buffers in the lab datapath.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 5, address width in bits.
- DEPTH, 32, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear engine.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  block can accept a request this cycle.
- mode  in  2  00 write-first, 01 read-first, 10 no-change, 11 treated as read-first.
- write_enable  in  1  request writes memory.
- byte_en  in  DATA_W/8  per-byte write mask; bit i covers data bits [8i+7:8i].
- address  in  ADDR_W  word address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data, registered.
- data_out_valid  out  1  data_out updated by the request accepted in the previous cycle.
- addr_err  out  1  one-cycle pulse: the previous accepted request had address >= DEPTH.
- busy  out  1  clear engine running.

Behaviour:
- Reset (clk, reset: synchronous, active-high):
  - data_out = 0, data_out_valid = 0, addr_err = 0, req_ready = 0.
  - busy = 1, FSM -> CLEAR, clear pointer = 0.
- FSM states: CLEAR, READY.
  - CLEAR: writes CLEAR_VAL to word[ptr] each cycle, then ptr++. Leaves after writing word DEPTH-1, i.e. DEPTH cycles after reset deasserts.
  - READY: busy = 0, req_ready = 1. It never leaves READY except via reset.
- Reset asserted during CLEAR or READY restarts CLEAR from ptr 0. Any in-flight result is discarded and valid is forced to 0.
- Request accepted when req_valid && req_ready. req_valid while !req_ready is ignored; it has no effect and is not queued.
- Merged word: new = for each byte i, byte_en[i] ? data_in byte i : old byte i. If write_enable = 0 or byte_en = 0, no memory change.
- Output on the cycle after acceptance (latency 1):
  - Write-first: data_out = new when write_enable = 1, else old; data_out_valid = 1.
  - Read-first / 11: data_out = old (pre-write contents); data_out_valid = 1.
  - No-change with write_enable = 1: data_out holds its previous value; data_out_valid = 0.
  - No-change with write_enable = 0: behaves as a read; data_out = old, data_out_valid = 1.
- Back-to-back requests, one per cycle: a read of the address written in the previous cycle returns the written value (no stale data).
- No accepted request in a cycle: data_out_valid = 0 and data_out holds.
- Out-of-range address (>= DEPTH):
  - Write is suppressed.
  - Result data = 0, data_out_valid = 1 (unless no-change write), addr_err = 1 for one cycle.
- Address is never wrapped modulo DEPTH.

Optional Feature:
- Macro: MODE_RAM_OUT_REG_EN.
- Defined: one extra output pipeline register. data_out, data_out_valid and addr_err appear 2 cycles after acceptance. Throughput is unchanged at one request per cycle. Reset clears both stages.
- Undefined: latency 1, as specified above.

Test Plan:
- Reset held 2 cycles, then released: busy = 1 for exactly 32 cycles, req_ready rises on cycle 33. Reading addresses 0..31 read-first returns 0 for all 32 words.
- Write-first write: write_enable = 1, byte_en = 4'hF, addr 5, data_in 32'hDEADBEEF -> next cycle data_out = DEADBEEF, valid = 1. Then a read-first write of 32'h12345678 to addr 5 -> data_out = DEADBEEF; a following read returns 12345678.
- Byte enables: addr 5 holds 12345678; write byte_en = 4'b0101, data_in AABBCCDD, mode write-first -> data_out = 12BB56DD.
- No-change: data_out currently 12BB56DD; write addr 3 with data 0000FFFF -> data_out stays 12BB56DD, valid = 0. Then a no-change read of addr 3 -> 0000FFFF, valid = 1.
- DEPTH = 20, ADDR_W = 5: write addr 25 then read addr 25 -> addr_err pulses after each, read data = 0, and addr 25 mod 20 = 5 is unmodified. Also: req_valid during CLEAR is ignored and the memory stays all-zero.
- Reset mid-stream: assert reset the cycle after accepting a read -> data_out_valid = 0, data_out = 0, CLEAR restarts from 0. With MODE_RAM_OUT_REG_EN defined, repeat the write-first case: result appears 2 cycles after acceptance.

Source files
------------

// File: rtl/mode_ram.sv
`default_nettype none
// ============================================================================
// mode_ram : single-port RAM with write-first / read-first / no-change modes,
//            byte enables and a post-reset clear engine.
//            Optional extra output register: MODE_RAM_OUT_REG_EN.
// Revision : 1.0
// ============================================================================
module mode_ram #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            mode,
  input  logic                  write_enable,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_out_valid,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int                c_nb    = DATA_W / 8;
  localparam int                c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_iw-1:0]   c_last  = c_iw'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {S_CLEAR, S_READY} state_t;

  state_t              r_state;
  logic [c_iw-1:0]     r_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_err;

  logic                w_accept;
  logic                w_in_range;
  logic                w_hold;
  logic                w_wr;
  logic [c_iw-1:0]     w_idx;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_result;

  // Range check is done on the full address so nothing ever wraps modulo DEPTH.
  assign w_in_range = {1'b0, address} < c_depth;
  assign w_idx      = address[c_iw-1:0];
  assign w_accept   = req_valid & req_ready & ~reset;
  assign w_hold     = (mode == 2'b10) & write_enable;
  assign w_wr       = w_accept & write_enable & w_in_range;
  assign w_old      = w_in_range ? r_mem[w_idx] : '0;

  for (genvar i = 0; i < c_nb; i++) begin : g_merge
    assign w_merged[8*i +: 8] = byte_en[i] ? data_in[8*i +: 8] : w_old[8*i +: 8];
  end

  assign w_result = !w_in_range ? '0 :
                    ((mode == 2'b00) && write_enable) ? w_merged : w_old;

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_ptr] <= CLEAR_VAL;
    end else if (w_wr) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_ptr     <= '0;
      busy      <= 1'b1;
      req_ready <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == c_last) begin
            r_state   <= S_READY;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
      // A no-change write leaves the previous read data in place.
      r_valid <= w_accept & ~w_hold;
      r_err   <= w_accept & ~w_in_range;
      if (w_accept && !w_hold) begin
        r_data <= w_result;
      end
    end
  end

`ifdef MODE_RAM_OUT_REG_EN
  logic [DATA_W-1:0] r_data_q;
  logic              r_valid_q;
  logic              r_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      r_data_q  <= r_data;
      r_valid_q <= r_valid;
      r_err_q   <= r_err;
    end
  end

  assign data_out       = r_data_q;
  assign data_out_valid = r_valid_q;
  assign addr_err       = r_err_q;
`else
  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign addr_err       = r_err;
`endif

endmodule
`default_nettype wire
